// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: gathers one strobed word per slot into shadow lanes
// and publishes a whole frame on dout once slot 3 arrives, tracking frame alignment.
module tdm_demux4 #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   din,
  input  logic                en,
  input  logic                frame_sync,
  output logic [4*DATA_W-1:0] dout,
  output logic                dout_valid,
  output logic [1:0]          sel,
  output logic                sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] lane0;
  logic [DATA_W-1:0] lane1;
  logic [DATA_W-1:0] lane2;

  // Slot 3 is never shadowed: it goes straight into dout together with lanes 0..2,
  // so dout only ever changes to a complete, single-frame word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      sel        <= 2'd0;
      lane0      <= '0;
      lane1      <= '0;
      lane2      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              lane0 <= din;
              sel   <= 2'd1;
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync anywhere but slot 0 restarts the frame from this word.
              sync_err <= (sel != 2'd0);
              lane0    <= din;
              sel      <= 2'd1;
            end else begin
              case (sel)
                2'd0: begin
                  sync_err <= 1'b1;
                  state    <= HUNT;
                end
                2'd1: begin
                  lane1 <= din;
                  sel   <= 2'd2;
                end
                2'd2: begin
                  lane2 <= din;
                  sel   <= 2'd3;
                end
                default: begin
                  dout       <= {din, lane2, lane1, lane0};
                  dout_valid <= 1'b1;
                  sel        <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state <= HUNT;
            sel   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomised and directed bench for tdm_demux4 (DATA_W=8) with a frame-level
// reference model feeding a scoreboard of expected frames and alignment errors.
module tb_tdm_demux4;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           en = 1'b0;
  logic           frame_sync = 1'b0;
  logic [4*W-1:0] dout;
  logic           dout_valid;
  logic [1:0]     sel;
  logic           sync_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit             is_err;
    logic [4*W-1:0] data;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: aligned flag, words of the frame being gathered, last published frame.
  bit             aligned = 1'b0;
  logic [W-1:0]   part[$];
  logic [4*W-1:0] last_frame = '0;

  tdm_demux4 #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .en         (en),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sel        (sel),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input bit r, input bit e, input bit f, input logic [W-1:0] d);
    ev_t ev;
    if (r) begin
      aligned    = 1'b0;
      part.delete();
      last_frame = '0;
    end else if (e) begin
      if (!aligned) begin
        if (f) begin
          aligned = 1'b1;
          part.delete();
          part.push_back(d);
        end
      end else if (f) begin
        if (part.size() != 0) begin
          ev.is_err = 1'b1;
          ev.data   = '0;
          exp_q.push_back(ev);
        end
        part.delete();
        part.push_back(d);
      end else if (part.size() == 0) begin
        ev.is_err = 1'b1;
        ev.data   = '0;
        exp_q.push_back(ev);
        aligned = 1'b0;
      end else begin
        part.push_back(d);
        if (part.size() == 4) begin
          last_frame = {part[3], part[2], part[1], part[0]};
          ev.is_err  = 1'b0;
          ev.data    = last_frame;
          exp_q.push_back(ev);
          part.delete();
        end
      end
    end
  endtask

  task automatic checkOutput(input string name);
    logic [1:0] exp_sel;
    exp_sel = 2'(part.size());
    tests++;
    if (sel !== exp_sel) begin
      fails++;
      $display("[TB] FAIL %s sel: got %0d expected %0d", name, sel, exp_sel);
    end
    tests++;
    if (dout !== last_frame) begin
      fails++;
      $display("[TB] FAIL %s dout: got %h expected %h", name, dout, last_frame);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit f, input logic [W-1:0] d,
                               input string name);
    @(negedge clk);
    rst        = r;
    en         = e;
    frame_sync = f;
    din        = d;
    @(posedge clk);
    modelStep(r, e, f, d);
    #1;
    checkOutput(name);
  endtask

  task automatic sendFrame(input logic [W-1:0] w0, w1, w2, w3, input string name);
    applyStimulus(1'b0, 1'b1, 1'b1, w0, name);
    applyStimulus(1'b0, 1'b1, 1'b0, w1, name);
    applyStimulus(1'b0, 1'b1, 1'b0, w2, name);
    applyStimulus(1'b0, 1'b1, 1'b0, w3, name);
  endtask

  // Every pulse on dout_valid or sync_err must match the oldest pending expectation.
  always @(negedge clk) begin
    ev_t got;
    if (dout_valid && sync_err) begin
      tests++;
      fails++;
      $display("[TB] FAIL pulse_overlap: dout_valid=%b sync_err=%b expected not both", dout_valid, sync_err);
    end else if (dout_valid || sync_err) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_pulse: dout_valid=%b sync_err=%b dout=%h expected no pulse",
                 dout_valid, sync_err, dout);
      end else begin
        got = exp_q.pop_front();
        if (got.is_err != sync_err) begin
          fails++;
          $display("[TB] FAIL pulse_kind: sync_err=%b expected sync_err=%b", sync_err, got.is_err);
        end else if (!got.is_err && dout !== got.data) begin
          fails++;
          $display("[TB] FAIL frame_data: got %h expected %h", dout, got.data);
        end
      end
    end
  end

  initial begin
    bit          e;
    bit          f;
    bit          r;
    logic [W-1:0] d;

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "reset");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A, "reset_priority");

    sendFrame(8'h01, 8'h00, 8'h01, 8'h01, "basic_1101");

    sendFrame(8'h11, 8'h22, 8'h33, 8'h44, "b2b_first");
    sendFrame(8'hA0, 8'hA1, 8'hA2, 8'hA3, "b2b_second");

    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB0, "en_gap");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, "en_gap");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, "en_gap");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hB1, "en_gap");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hDD, "en_gap");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hB2, "en_gap");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hCC, "en_gap");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hB3, "en_gap");

    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC0, "early_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hC1, "early_sync");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hD0, "early_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hD1, "early_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hD2, "early_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hD3, "early_sync");

    sendFrame(8'hE0, 8'hE1, 8'hE2, 8'hE3, "pre_sync3");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hF0, "early_sync_slot3");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hF1, "early_sync_slot3");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hF2, "early_sync_slot3");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hF3, "early_sync_slot3");

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h91, "missing_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h92, "missing_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h93, "missing_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h94, "missing_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h95, "missing_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h96, "missing_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h97, "missing_sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h98, "missing_sync");
    sendFrame(8'h61, 8'h62, 8'h63, 8'h64, "resync");

    applyStimulus(1'b0, 1'b1, 1'b1, 8'h71, "mid_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h72, "mid_reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h73, "mid_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h74, "mid_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h75, "mid_reset");

    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      if (part.size() == 0)
        f = ($urandom_range(0, 7) != 0);
      else
        f = ($urandom_range(0, 15) == 0);
      d = W'($urandom);
      applyStimulus(r, e, f, d, "random");
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "drain");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "drain");
    @(negedge clk);
    #1;

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: DATA_W, default 1, width of one time slot word (lane width).
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  reset; synchronous to clk, active-high.
REQ-004 din  input  DATA_W  time-multiplexed sample, valid when en=1.
REQ-005 en  input  1  sample strobe; one slot consumed per clk with en=1.
REQ-006 frame_sync  input  1  qualified by en; marks din as slot 0 of a frame.
REQ-007 dout  output  4*DATA_W  registered de-multiplexed frame; lane k at dout[DATA_W*k +: DATA_W].
REQ-008 dout_valid  output  1  one-cycle pulse; dout holds a newly completed frame.
REQ-009 sel  output  2  registered index of the slot the next en=1 sample fills.
REQ-010 sync_err  output  1  one-cycle pulse on frame-alignment violation.

Function
REQ-011 The block SHALL contain two states: HUNT (unaligned) and LOCKED (aligned).
REQ-012 The block SHALL hold all state, sel and dout on any cycle with en=0; dout_valid and sync_err SHALL be 0 on such cycles.
REQ-013 HUNT, en=1, frame_sync=0: sample discarded, no output change, remain HUNT.
REQ-014 HUNT, en=1, frame_sync=1: din stored in shadow lane 0, sel<=1, state<=LOCKED.
REQ-015 LOCKED, en=1, frame_sync=0, sel in {1,2}: din stored in shadow lane sel, sel<=sel+1.
REQ-016 LOCKED, en=1, frame_sync=0, sel=3: dout<={din, shadow lane 2, lane 1, lane 0}, dout_valid=1 for the following cycle only, sel<=0.
REQ-017 Latency: dout and dout_valid SHALL update at the same clk edge that samples the slot-3 word (one cycle from slot-3 presentation to visible output).
REQ-018 LOCKED, en=1, sel=0, frame_sync=1: normal frame start; din to shadow lane 0, sel<=1.
REQ-019 LOCKED, en=1, sel=0, frame_sync=0 (missing sync): sync_err pulse, sample discarded, sel<=0, state<=HUNT.
REQ-020 LOCKED, en=1, sel!=0, frame_sync=1 (early sync): sync_err pulse, partial frame discarded (no dout_valid, dout unchanged), din stored as lane 0, sel<=1, remain LOCKED.
REQ-021 Early sync at sel=3 SHALL take precedence over REQ-016: no frame emitted.
REQ-022 Shadow lanes SHALL not be visible on dout until a complete 4-slot frame finishes; dout SHALL never mix words from two frames.
REQ-023 sel SHALL wrap 3->0 modulo 4; no other sel sequence is legal in LOCKED.
REQ-024 dout_valid and sync_err SHALL never assert in the same cycle.

Reset
REQ-025 With rst=1 at a clk edge: state<=HUNT, sel<=0, shadow lanes<=0, dout<=0, dout_valid<=0, sync_err<=0.
REQ-026 rst SHALL take priority over en, frame_sync and din; a frame in progress is discarded without dout_valid.
REQ-027 First cycle after rst deasserts SHALL behave as HUNT per REQ-013/014.

Verification
REQ-028 DATA_W=1, reset, then en=1 for 4 cycles, din=1,0,1,1 with frame_sync on first -> dout=4'b1101, dout_valid one cycle, sel sequence 1,2,3,0.
REQ-029 DATA_W=8, two back-to-back frames 0x11,0x22,0x33,0x44 then 0xA0..0xA3 -> dout=0x44332211 then 0xA3A2A1A0, each with single dout_valid pulse, no sync_err.
REQ-030 en toggled 1,0,0,1,... during a frame -> identical dout as contiguous case, sel held during en=0, dout_valid only after 4th strobed sample.
REQ-031 frame_sync asserted at sel=2 -> sync_err pulse, no dout_valid, next 3 samples complete a new frame using the early-sync word as lane 0.
REQ-032 LOCKED, sel=0 sample without frame_sync -> sync_err pulse, state HUNT; following samples ignored until frame_sync; samples before sync never on dout.
REQ-033 rst pulsed after 2 slots of a frame -> dout=0, sel=0, dout_valid=0; subsequent non-sync samples ignored (HUNT).
